// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI mode-0 slave receiver.
// Frame lengths, rx_len encoding and the endpoint FSM state type live here.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        WAIT_DESEL = 2'd0,
        IDLE       = 2'd1,
        ACTIVE     = 2'd2
    } state_e;

    localparam int FRAME16 = 16;
    localparam int FRAME32 = 32;
    localparam int CNT_W   = 6;

    localparam logic LEN16 = 1'b0;
    localparam logic LEN32 = 1'b1;

    function automatic logic [31:0] zext16(input logic [15:0] word);
        return {16'h0000, word};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin with registered rise/fall strobes.
// The chain resets to 0, so a pin that is high after reset reports one rise strobe.
module spi_sync_edge
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic din_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave endpoint: oversamples the SPI pins in the pclk domain, assembles
// MSB-first 16/32-bit frames, hands them out over valid/ready and shifts a response on MISO.
module spi_slave_rx
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 32
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_len,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_err,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load
);

    localparam logic [CNT_W-1:0] CNT16 = 6'(FRAME16);
    localparam logic [CNT_W-1:0] CNT32 = 6'(FRAME32);

    logic sclkRise;
    logic sclkFall;
    logic csRise;
    logic csFall;

    logic [SYNC_STAGES-1:0] mosiSync_q;
    logic                   mosiBit;

    state_e            state_q,    state_d;
    logic [CNT_W-1:0]  bitCnt_q,   bitCnt_d;
    logic [DATA_W-1:0] rxShift_q,  rxShift_d;
    logic [DATA_W-1:0] txShift_q,  txShift_d;
    logic [DATA_W-1:0] txShadow_q, txShadow_d;
    logic [DATA_W-1:0] rxData_q,   rxData_d;
    logic              rxLen_q,    rxLen_d;
    logic              rxValid_q,  rxValid_d;
    logic              rxErr_q,    rxErr_d;

    logic              emit;
    logic              emitLen;
    logic [DATA_W-1:0] emitData;
    logic              frameErr;
    logic [CNT_W-1:0]  cntNext;
    logic [DATA_W-1:0] rxNext;

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sclk_sync (
        .clk_i  (pclk),
        .reset_i(preset),
        .din_i  (spi_sclk),
        .rise_o (sclkRise),
        .fall_o (sclkFall)
    );

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_cs_sync (
        .clk_i  (pclk),
        .reset_i(preset),
        .din_i  (spi_cs_n),
        .rise_o (csRise),
        .fall_o (csFall)
    );

    // MOSI needs only the level; it is stable around every sclk rise strobe.
    always_ff @(posedge pclk) begin
        if (preset) begin
            mosiSync_q <= '0;
        end else begin
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign mosiBit = mosiSync_q[SYNC_STAGES-1];

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= WAIT_DESEL;
        end else begin
            state_q <= state_d;
        end
    end

    // Synchronized cs_n starts at 0, so leaving WAIT_DESEL on its rise strobe means "seen deselected".
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_DESEL: if (csRise) state_d = IDLE;
            IDLE:       if (csFall) state_d = ACTIVE;
            ACTIVE:     if (csRise) state_d = IDLE;
            default:    state_d = WAIT_DESEL;
        endcase
    end

    always_comb begin
        bitCnt_d   = bitCnt_q;
        rxShift_d  = rxShift_q;
        txShift_d  = txShift_q;
        txShadow_d = tx_load ? tx_data : txShadow_q;
        emit       = 1'b0;
        emitLen    = LEN16;
        emitData   = '0;
        frameErr   = 1'b0;
        cntNext    = bitCnt_q + {{(CNT_W-1){1'b0}}, sclkRise};
        rxNext     = sclkRise ? {rxShift_q[DATA_W-2:0], mosiBit} : rxShift_q;

        unique case (state_q)
            WAIT_DESEL: ;
            IDLE: begin
                if (csFall) begin
                    bitCnt_d  = '0;
                    txShift_d = txShadow_q;
                end
            end
            ACTIVE: begin
                bitCnt_d  = cntNext;
                rxShift_d = rxNext;
                // A fall with count 0 only follows a 32-bit wrap: the reloaded MSB must stay on the pin.
                if (sclkFall && (bitCnt_q != '0)) begin
                    txShift_d = {txShift_q[DATA_W-2:0], 1'b0};
                end
                if (cntNext == CNT32) begin
                    emit      = 1'b1;
                    emitLen   = LEN32;
                    emitData  = rxNext;
                    bitCnt_d  = '0;
                    txShift_d = txShadow_q;
                end else if (csRise) begin
                    if (cntNext == CNT16) begin
                        emit     = 1'b1;
                        emitLen  = LEN16;
                        emitData = zext16(rxNext[15:0]);
                    end else if (cntNext != '0) begin
                        frameErr = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        rxData_d  = rxData_q;
        rxLen_d   = rxLen_q;
        rxValid_d = rxValid_q;
        rxErr_d   = frameErr;
        if (emit) begin
            if (!rxValid_q || rx_ready) begin
                rxData_d  = emitData;
                rxLen_d   = emitLen;
                rxValid_d = 1'b1;
            end else begin
                rxErr_d = 1'b1;
            end
        end else if (rxValid_q && rx_ready) begin
            rxValid_d = 1'b0;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            bitCnt_q   <= '0;
            rxShift_q  <= '0;
            txShift_q  <= '0;
            txShadow_q <= '0;
            rxData_q   <= '0;
            rxLen_q    <= LEN16;
            rxValid_q  <= 1'b0;
            rxErr_q    <= 1'b0;
        end else begin
            bitCnt_q   <= bitCnt_d;
            rxShift_q  <= rxShift_d;
            txShift_q  <= txShift_d;
            txShadow_q <= txShadow_d;
            rxData_q   <= rxData_d;
            rxLen_q    <= rxLen_d;
            rxValid_q  <= rxValid_d;
            rxErr_q    <= rxErr_d;
        end
    end

    always_comb begin
        spi_miso = (state_q == ACTIVE) ? txShift_q[DATA_W-1] : 1'b0;
        rx_data  = rxData_q;
        rx_len   = rxLen_q;
        rx_valid = rxValid_q;
        rx_err   = rxErr_q;
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: a behavioural SPI master plus a frame-level
// reference model (bit queue arithmetic, one-slot consumer model, repeated shadow on MISO).
module tb_spi_slave_rx;

    localparam int HALF     = 6;
    localparam int CS_SETUP = 8;
    localparam int CS_HOLD  = 12;

    logic        pclk = 1'b0;
    logic        preset;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [31:0] rx_data;
    logic        rx_len;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_err;
    logic [31:0] tx_data;
    logic        tx_load;

    int vectors     = 0;
    int miscompares = 0;

    logic [32:0] gotQ[$];
    logic [32:0] expQ[$];
    int          errSeen    = 0;
    int          errExp     = 0;
    int          checkedIdx = 0;
    logic        slotValid  = 1'b0;
    logic [32:0] slotWord   = '0;
    logic [31:0] modelShadow = '0;

    always #5 pclk = ~pclk;

    spi_slave_rx #(
        .SYNC_STAGES(2),
        .DATA_W     (32)
    ) dut (
        .pclk    (pclk),
        .preset  (preset),
        .spi_sclk(spi_sclk),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .rx_data (rx_data),
        .rx_len  (rx_len),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_err  (rx_err),
        .tx_data (tx_data),
        .tx_load (tx_load)
    );

    // Inputs change just after posedge, so a negedge sample sees the handshake of the next edge.
    always @(negedge pclk) begin
        if (rx_valid && rx_ready) gotQ.push_back({rx_len, rx_data});
        if (rx_err) errSeen++;
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic compareResults(input string tag);
        checkOutput({tag, "_count"}, 64'(gotQ.size()), 64'(expQ.size()));
        for (int i = checkedIdx; i < gotQ.size() && i < expQ.size(); i++) begin
            checkOutput($sformatf("%s_word%0d", tag, i), 64'(gotQ[i]), 64'(expQ[i]));
        end
        checkOutput({tag, "_errs"}, 64'(errSeen), 64'(errExp));
        checkedIdx = (gotQ.size() > expQ.size()) ? gotQ.size() : expQ.size();
    endtask

    task automatic modelEmit(input logic len, input logic [31:0] data);
        if (slotValid) errExp++;
        else if (rx_ready) expQ.push_back({len, data});
        else begin
            slotWord  = {len, data};
            slotValid = 1'b1;
        end
    endtask

    task automatic modelSession(input logic [63:0] bits, input int n);
        logic [63:0] shifted;
        int full;
        int rem;
        full = n / 32;
        rem  = n % 32;
        for (int k = 0; k < full; k++) begin
            shifted = bits >> (n - 32 * (k + 1));
            modelEmit(1'b1, shifted[31:0]);
        end
        if (rem == 16) modelEmit(1'b0, {16'h0000, bits[15:0]});
        else if (rem != 0) errExp++;
    endtask

    function automatic logic [63:0] expectedMiso(input logic [31:0] shadow, input int n);
        logic [63:0] acc;
        acc = '0;
        for (int j = 0; j < n; j++) acc = {acc[62:0], shadow[31 - (j % 32)]};
        return acc;
    endfunction

    task automatic setReady(input logic v);
        rx_ready = v;
        if (v && slotValid) begin
            expQ.push_back(slotWord);
            slotValid = 1'b0;
        end
    endtask

    task automatic loadShadow(input logic [31:0] v);
        tx_data = v;
        tx_load = 1'b1;
        waitCycles(1);
        tx_load = 1'b0;
        modelShadow = v;
    endtask

    task automatic shiftBits(input logic [63:0] bits, input int n, input int loadAt,
                             input logic [31:0] loadVal, output logic [63:0] misoCap);
        misoCap = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = bits[i];
            if (n - 1 - i == loadAt) begin
                tx_data = loadVal;
                tx_load = 1'b1;
                waitCycles(1);
                tx_load = 1'b0;
                waitCycles(HALF - 1);
            end else begin
                waitCycles(HALF);
            end
            spi_sclk = 1'b1;
            misoCap  = {misoCap[62:0], spi_miso};
            waitCycles(HALF);
            spi_sclk = 1'b0;
        end
        spi_mosi = 1'b0;
    endtask

    task automatic csLow();
        spi_cs_n = 1'b0;
        waitCycles(CS_SETUP);
    endtask

    task automatic csHigh();
        waitCycles(HALF);
        spi_cs_n = 1'b1;
        waitCycles(CS_HOLD);
    endtask

    task automatic applyStimulus(input logic [63:0] bits, input int n, input int loadAt,
                                 input logic [31:0] loadVal, output logic [63:0] misoCap);
        csLow();
        shiftBits(bits, n, loadAt, loadVal, misoCap);
        csHigh();
        modelSession(bits, n);
        if (loadAt >= 0) modelShadow = loadVal;
    endtask

    initial begin
        logic [63:0] cap;
        logic [63:0] bits;
        logic [31:0] shadowUsed;
        int          n;
        int          sel;

        preset   = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        rx_ready = 1'b1;
        tx_data  = '0;
        tx_load  = 1'b0;
        waitCycles(3);
        checkOutput("reset_rx_valid", 64'(rx_valid), 64'd0);
        checkOutput("reset_rx_data", 64'(rx_data), 64'd0);
        checkOutput("reset_rx_len", 64'(rx_len), 64'd0);
        checkOutput("reset_rx_err", 64'(rx_err), 64'd0);
        checkOutput("reset_miso", 64'(spi_miso), 64'd0);
        preset = 1'b0;
        waitCycles(10);

        // Reset shadow is zero, so the first frame must shift out zeros.
        applyStimulus(64'h17f3ad08, 32, -1, 32'h0, cap);
        compareResults("dword");
        checkOutput("dword_miso", cap[31:0], 64'd0);

        applyStimulus(64'h17f3ad08_dead, 48, -1, 32'h0, cap);
        compareResults("held_cs");

        applyStimulus(64'h2a5, 10, -1, 32'h0, cap);
        compareResults("frame_err");
        applyStimulus(64'hfeed, 16, -1, 32'h0, cap);
        compareResults("after_err");

        setReady(1'b0);
        applyStimulus(64'h1234, 16, -1, 32'h0, cap);
        applyStimulus(64'h5678, 16, -1, 32'h0, cap);
        checkOutput("overrun_valid", 64'(rx_valid), 64'd1);
        checkOutput("overrun_data", 64'(rx_data), 64'h1234);
        checkOutput("overrun_len", 64'(rx_len), 64'd0);
        setReady(1'b1);
        waitCycles(3);
        compareResults("overrun");
        checkOutput("overrun_drained", 64'(rx_valid), 64'd0);

        loadShadow(32'ha5a50f0f);
        applyStimulus(64'h0badf00d, 32, 12, 32'h11111111, cap);
        checkOutput("miso_a5a5", cap[31:0], 64'ha5a50f0f);
        compareResults("miso_frame");
        applyStimulus(64'h01234567_89abcdef, 64, -1, 32'h0, cap);
        checkOutput("miso_after_load", cap, expectedMiso(32'h11111111, 64));
        compareResults("miso_held");
        checkOutput("miso_idle", 64'(spi_miso), 64'd0);

        csLow();
        shiftBits(64'hc3, 8, -1, 32'h0, cap);
        preset = 1'b1;
        waitCycles(1);
        preset = 1'b0;
        modelShadow = 32'h0;
        shiftBits(64'h00abcdef, 24, -1, 32'h0, cap);
        csHigh();
        compareResults("reset_mid");
        applyStimulus(64'hdeadbeef, 32, -1, 32'h0, cap);
        compareResults("after_reset");

        for (int k = 0; k < 8; k++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: n = 16;
                1: n = 32;
                2: n = 48;
                3: n = 64;
                default: n = int'($urandom_range(1, 64));
            endcase
            bits = {$urandom, $urandom};
            loadShadow($urandom);
            shadowUsed = modelShadow;
            applyStimulus(bits, n, -1, 32'h0, cap);
            compareResults($sformatf("rand%0d", k));
            checkOutput($sformatf("rand%0d_miso", k), cap, expectedMiso(shadowUsed, n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI mode-0 slave endpoint that terminates the SPI link driven by the bench SPI master. It oversamples `spi_sclk`/`spi_cs_n`/`spi_mosi` in the `pclk` domain and assembles MSB-first 16- or 32-bit frames. Completed words are handed to the register side through a valid/ready handshake, and a preloaded response word is shifted back on `spi_miso`.

## Interface

Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for `spi_sclk`, `spi_cs_n`, `spi_mosi` (≥2).
- `DATA_W`, 32: maximum frame width; must be 32.

Ports:
- `pclk` in 1: system clock; single clock domain.
- `preset` in 1: synchronous, active-high reset.
- `spi_sclk` in 1: SPI clock, asynchronous to `pclk`; idle low (CPOL=0).
- `spi_cs_n` in 1: chip select, active low, asynchronous.
- `spi_mosi` in 1: serial data in, sampled on `spi_sclk` rising edge.
- `spi_miso` out 1: serial data out, updated on `spi_sclk` falling edge; 0 while deselected.
- `rx_data` out 32: received word. 16-bit frames are right-aligned and zero-extended.
- `rx_len` out 1: 0 = 16-bit frame, 1 = 32-bit frame.
- `rx_valid` out 1: `rx_data`/`rx_len` hold a word; held until accepted.
- `rx_ready` in 1: consumer accepts the word when `rx_valid && rx_ready`.
- `rx_err` out 1: one-cycle pulse on framing error or overrun.
- `tx_data` in 32: response word for the next frame.
- `tx_load` in 1: latch `tx_data` into the TX shadow register.

## Operation

- `spi_sclk`, `spi_cs_n` and `spi_mosi` each pass through `SYNC_STAGES` flops. Registered edge detect produces `sclk_rise`, `sclk_fall`, `cs_fall` and `cs_rise` strobes.

FSM states:
- `WAIT_DESEL`: entered from reset. Moves to `IDLE` once synchronized `cs_n`=1. This prevents capturing a partial frame after reset mid-transfer.
- `IDLE`: on `cs_fall`, clear the bit counter, copy the TX shadow into the TX shift register, drive its MSB on `spi_miso`, and go to `ACTIVE`.
- `ACTIVE`:
  - On `sclk_rise`: shift the `mosi` sample into the RX shift register (MSB first) and increment the 6-bit bit counter.
  - On `sclk_fall`: shift the TX register left and drive the new MSB.
  - When the count reaches 32 with CS still low: emit a 32-bit word, reset the count to 0, reload the TX shift register from the shadow, and stay in `ACTIVE` (back-to-back frames under held CS).
  - On `cs_rise`:
    - count 16: emit a 16-bit word.
    - count 32: not possible here; already emitted.
    - count 0: no word.
    - any other count: `rx_err` pulse, data discarded.
  - Then go to `IDLE`.

Emit and output rules:
- Emit with `rx_valid`=0, or with `rx_valid`=1 and `rx_ready`=1 in the same cycle: load `rx_data`/`rx_len` and set `rx_valid`.
- Emit with `rx_valid`=1 and `rx_ready`=0: overrun. The new word is dropped, the held word is unchanged, and `rx_err` pulses.
- `tx_load` writes the shadow at any time. The shift register only copies the shadow at frame start.
- `spi_miso` is 0 in `WAIT_DESEL` and `IDLE`.

## Timing

- Reset values: `rx_data`=0, `rx_len`=0, `rx_valid`=0, `rx_err`=0, `spi_miso`=0, TX shadow=0, state=`WAIT_DESEL`.
- Edge strobe latency: a strobe is high in cycle SYNC_STAGES+1 after the pin edge is first sampled.
- `rx_valid` latency: `rx_valid` rises one cycle after the strobe, i.e. SYNC_STAGES+2 `pclk` edges after the 32nd `sclk` rising edge or after the `cs_n` rising edge.
- MISO latency: `spi_miso` updates SYNC_STAGES+2 cycles after the `sclk` falling pin edge.
- Clock ratio: the `sclk` half-period must be at least SYNC_STAGES+2 `pclk` cycles (≥4 at default). Faster clocks are unsupported.
- CS setup: `cs_n` fall-to-first-`sclk` rise must be at least SYNC_STAGES+2 cycles.
- Handshake: `rx_valid` stays high and `rx_data` stays stable until the cycle with `rx_ready`=1. `rx_valid` drops the next cycle unless a new emit coincides.
- Same-cycle `sclk_rise` and `cs_rise`: the bit is counted first, then the frame is closed.
- `preset` mid-frame: all state clears next edge; the partial frame is lost, with no `rx_err`.

## Structure

- Package `spi_slave_pkg`:
  - State enum `{WAIT_DESEL, IDLE, ACTIVE}`.
  - Constants `FRAME16=16`, `FRAME32=32`.
  - `rx_len` encoding `LEN16=1'b0`, `LEN32=1'b1`.
- Sub-module `spi_sync_edge`: parameterized synchronizer plus registered rise/fall detect. Instantiated for `sclk` and `cs_n`; `mosi` uses the synchronizer only.

## Test plan

- Single dword: CS low, shift 0x17f3ad08, CS high, `rx_ready`=1 → one `rx_valid` with `rx_data`=0x17f3ad08, `rx_len`=1, no `rx_err`.
- Held CS: dword 0x17f3ad08 then word 0xdead without deasserting CS → two words in order: 0x17f3ad08 (`len` 1), then 0x0000dead (`len` 0).
- Framing error: CS high after 10 bits → `rx_err` pulses once, no `rx_valid`. The next 16-bit frame 0xfeed is received correctly.
- Overrun: `rx_ready`=0, send 0x00001234 then 0x00005678 → `rx_data` stays 0x00001234 with `rx_valid`=1 and one `rx_err` pulse. Raising `rx_ready` delivers 0x1234 only.
- MISO: `tx_load` 0xa5a50f0f, then a 32-bit frame → the master samples 0xa5a50f0f on rising edges. A `tx_load` of 0x11111111 mid-frame does not alter the current frame.
- Reset mid-frame: `preset` after 8 bits with CS held low, remaining bits sent → nothing emitted. The next full frame 0xdeadbeef after a CS high is received intact.
